// File: rtl/scalar_writeback_arbiter_if.sv
// Writeback bus: ALU and load result inputs, register-file write port and
// hazard/status outputs of the scalar writeback arbiter.
interface scalar_writeback_arbiter_if #(
  parameter int BIT_NUMBER      = 32,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int MEM_FIFO_DEPTH  = 4
);
  logic                                wb_stall;
  logic                                alu_valid;
  logic                                alu_ready;
  logic [ADDR_NUMBER-1:0]              alu_dest;
  logic [BIT_NUMBER-1:0]               alu_data;
  logic                                mem_valid;
  logic [ADDR_NUMBER-1:0]              mem_dest;
  logic [BIT_NUMBER-1:0]               mem_data;
  logic                                write_enable;
  logic [ADDR_NUMBER-1:0]              dest_addr;
  logic [BIT_NUMBER-1:0]               write_data;
  logic [REGISTER_NUMBER-1:0]          pending_mask;
  logic [$clog2(MEM_FIFO_DEPTH):0]     mem_fifo_count;
  logic                                overflow;
  logic                                addr_error;

  modport master (
    output wb_stall, alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  alu_ready, write_enable, dest_addr, write_data, pending_mask,
           mem_fifo_count, overflow, addr_error
  );

  modport slave (
    input  wb_stall, alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output alu_ready, write_enable, dest_addr, write_data, pending_mask,
           mem_fifo_count, overflow, addr_error
  );
endinterface

// File: rtl/scalar_writeback_arbiter.sv
// Merges ALU results and non-stallable load results (buffered in a small FIFO)
// onto the single scalar register-file write port; publishes load hazards.
module scalar_writeback_arbiter #(
  parameter int BIT_NUMBER      = 32,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int MEM_FIFO_DEPTH  = 4
) (
  input logic                        clk,
  input logic                        reset,
  scalar_writeback_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(MEM_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FULL_CNT  = CNT_W'(MEM_FIFO_DEPTH);
  localparam logic [ADDR_NUMBER:0]   REG_LIMIT = (ADDR_NUMBER+1)'(REGISTER_NUMBER);

  logic [ADDR_NUMBER-1:0]     r_fifo_dest [MEM_FIFO_DEPTH];
  logic [BIT_NUMBER-1:0]      r_fifo_data [MEM_FIFO_DEPTH];
  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [CNT_W-1:0]           r_count;
  logic                       r_overflow;
  logic                       r_addr_error;
  logic                       r_we_p1;
  logic [ADDR_NUMBER-1:0]     r_dest_p1;
  logic [BIT_NUMBER-1:0]      r_data_p1;

  logic                       w_commit_ok;
  logic                       w_fifo_empty;
  logic                       w_fifo_full;
  logic                       w_pop;
  logic                       w_bypass;
  logic                       w_alu_ready;
  logic                       w_alu_take;
  logic                       w_push_req;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_sel_vld_p0;
  logic [ADDR_NUMBER-1:0]     w_sel_dest_p0;
  logic [BIT_NUMBER-1:0]      w_sel_data_p0;
  logic                       w_in_range_p0;
  logic [MEM_FIFO_DEPTH-1:0]  w_entry_vld;
  logic [REGISTER_NUMBER-1:0] w_pending;

  assign w_commit_ok  = !reset && !bus.wb_stall;
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FULL_CNT);

  // Buffered loads always drain before a new load or an ALU result may commit.
  assign w_pop       = w_commit_ok && !w_fifo_empty;
  assign w_bypass    = w_commit_ok && w_fifo_empty && bus.mem_valid;
  assign w_alu_ready = w_commit_ok && w_fifo_empty && !bus.mem_valid;
  assign w_alu_take  = w_alu_ready && bus.alu_valid;

  assign w_push_req = !reset && bus.mem_valid && !w_bypass;
  assign w_push     = w_push_req && (!w_fifo_full || w_pop);
  assign w_drop     = w_push_req && w_fifo_full && !w_pop;

  // ---- stage p0: source selection ----
  always_comb begin
    w_sel_vld_p0  = 1'b0;
    w_sel_dest_p0 = '0;
    w_sel_data_p0 = '0;
    if (w_pop) begin
      w_sel_vld_p0  = 1'b1;
      w_sel_dest_p0 = r_fifo_dest[r_head];
      w_sel_data_p0 = r_fifo_data[r_head];
    end else if (w_bypass) begin
      w_sel_vld_p0  = 1'b1;
      w_sel_dest_p0 = bus.mem_dest;
      w_sel_data_p0 = bus.mem_data;
    end else if (w_alu_take) begin
      w_sel_vld_p0  = 1'b1;
      w_sel_dest_p0 = bus.alu_dest;
      w_sel_data_p0 = bus.alu_data;
    end
  end

  assign w_in_range_p0 = ({1'b0, w_sel_dest_p0} < REG_LIMIT);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dest[r_tail] <= bus.mem_dest;
      r_fifo_data[r_tail] <= bus.mem_data;
    end
  end

  // ---- stage p1: registered write port, FIFO control, sticky flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_addr_error <= 1'b0;
      r_we_p1      <= 1'b0;
      r_dest_p1    <= '0;
      r_data_p1    <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      r_we_p1 <= w_sel_vld_p0 && w_in_range_p0;
      if (w_sel_vld_p0 && w_in_range_p0) begin
        r_dest_p1 <= w_sel_dest_p0;
        r_data_p1 <= w_sel_data_p0;
      end
      if (w_sel_vld_p0 && !w_in_range_p0) r_addr_error <= 1'b1;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    w_entry_vld = '0;
    for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
      w_entry_vld[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
    end
  end

  always_comb begin
    w_pending = '0;
    for (int r = 0; r < REGISTER_NUMBER; r++) begin
      for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
        if (w_entry_vld[i] && (r_fifo_dest[i] == ADDR_NUMBER'(r))) w_pending[r] = 1'b1;
      end
    end
  end

  assign bus.alu_ready      = w_alu_ready;
  assign bus.write_enable   = r_we_p1;
  assign bus.dest_addr      = r_dest_p1;
  assign bus.write_data     = r_data_p1;
  assign bus.pending_mask   = w_pending;
  assign bus.mem_fifo_count = r_count;
  assign bus.overflow       = r_overflow;
  assign bus.addr_error     = r_addr_error;
endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed and randomized bench for scalar_writeback_arbiter against a
// queue-based reference model of the writeback rules.
module tb_scalar_writeback_arbiter;
  localparam int BN = 32;
  localparam int AN = 5;
  localparam int RN = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scalar_writeback_arbiter_if #(.BIT_NUMBER(BN), .ADDR_NUMBER(AN),
    .REGISTER_NUMBER(RN), .MEM_FIFO_DEPTH(FD)) bus ();

  scalar_writeback_arbiter #(.BIT_NUMBER(BN), .ADDR_NUMBER(AN),
    .REGISTER_NUMBER(RN), .MEM_FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AN-1:0] dest;
    logic [BN-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic          m_we;
  logic [AN-1:0] m_dest;
  logic [BN-1:0] m_data;
  logic          m_ovf;
  logic          m_aerr;
  logic          exp_ready_last;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RN-1:0] model_mask();
    logic [RN-1:0] m = '0;
    foreach (q[i]) begin
      for (int r = 0; r < RN; r++) if (int'(q[i].dest) == r) m[r] = 1'b1;
    end
    return m;
  endfunction

  task automatic step(input logic rst, input logic stall,
                      input logic av, input logic [AN-1:0] ad, input logic [BN-1:0] adat,
                      input logic mv, input logic [AN-1:0] md, input logic [BN-1:0] mdat);
    ent_t c;
    bit   have;
    bit   used;
    reset         = rst;
    bus.wb_stall  = stall;
    bus.alu_valid = av;
    bus.alu_dest  = ad;
    bus.alu_data  = adat;
    bus.mem_valid = mv;
    bus.mem_dest  = md;
    bus.mem_data  = mdat;
    #1;
    exp_ready_last = !rst && !stall && (q.size() == 0) && !mv;
    chk("alu_ready", 64'(bus.alu_ready), 64'(exp_ready_last));
    have = 0;
    used = 0;
    c    = '0;
    if (rst) begin
      q.delete();
      m_we = 0; m_dest = '0; m_data = '0; m_ovf = 0; m_aerr = 0;
    end else begin
      if (!stall) begin
        if (q.size() > 0) begin
          c = q.pop_front(); have = 1;
        end else if (mv) begin
          c.dest = md; c.data = mdat; have = 1; used = 1;
        end else if (av) begin
          c.dest = ad; c.data = adat; have = 1;
        end
      end
      if (mv && !used) begin
        if (q.size() < FD) q.push_back(ent_t'{dest: md, data: mdat});
        else m_ovf = 1;
      end
      if (have && int'(c.dest) < RN) begin
        m_we = 1; m_dest = c.dest; m_data = c.data;
      end else begin
        m_we = 0;
        if (have) m_aerr = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("write_enable", 64'(bus.write_enable), 64'(m_we));
    chk("dest_addr", 64'(bus.dest_addr), 64'(m_dest));
    chk("write_data", 64'(bus.write_data), 64'(m_data));
    chk("fifo_count", 64'(bus.mem_fifo_count), 64'(q.size()));
    chk("pending_mask", 64'(bus.pending_mask), 64'(model_mask()));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("addr_error", 64'(bus.addr_error), 64'(m_aerr));
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic          a_v;
    logic [AN-1:0] a_d;
    logic [BN-1:0] a_dat;
    logic          rst;
    logic          stall;
    logic          mv;
    logic [AN-1:0] md;
    logic [BN-1:0] mdat;

    step(1, 0, 0, '0, '0, 0, '0, '0);
    chk("reset_we", 64'(bus.write_enable), 64'h0);
    chk("reset_count", 64'(bus.mem_fifo_count), 64'h0);

    step(0, 0, 1, 5'd3, 32'h0000_00AA, 0, '0, '0);
    chk("alu_first_dest", 64'(bus.dest_addr), 64'd3);
    chk("alu_first_data", 64'(bus.write_data), 64'hAA);
    idle();
    chk("alu_one_pulse", 64'(bus.write_enable), 64'h0);

    step(0, 0, 1, 5'd6, 32'h66, 1, 5'd5, 32'h1234);
    chk("load_first_dest", 64'(bus.dest_addr), 64'd5);
    step(0, 0, 1, 5'd6, 32'h66, 0, '0, '0);
    chk("alu_after_load", 64'(bus.dest_addr), 64'd6);
    idle();

    for (int d = 1; d <= 4; d++) step(0, 1, 0, '0, '0, 1, AN'(d), 32'h100 + 32'(d));
    chk("fill_count", 64'(bus.mem_fifo_count), 64'd4);
    chk("fill_mask", 64'(bus.pending_mask), 64'h001E);
    step(0, 1, 0, '0, '0, 1, 5'd7, 32'h777);
    chk("overflow_set", 64'(bus.overflow), 64'h1);
    chk("overflow_count", 64'(bus.mem_fifo_count), 64'd4);
    step(0, 0, 0, '0, '0, 1, 5'd8, 32'h888);
    chk("full_pop_push_dest", 64'(bus.dest_addr), 64'd1);
    chk("full_pop_push_count", 64'(bus.mem_fifo_count), 64'd4);
    for (int k = 0; k < 4; k++) idle();
    chk("drained_mask", 64'(bus.pending_mask), 64'h0);
    idle();

    step(0, 0, 1, 5'd20, 32'hDEAD, 0, '0, '0);
    chk("range_we", 64'(bus.write_enable), 64'h0);
    chk("range_aerr", 64'(bus.addr_error), 64'h1);
    idle();
    idle();

    for (int d = 9; d <= 11; d++) step(0, 1, 0, '0, '0, 1, AN'(d), 32'h900 + 32'(d));
    step(1, 0, 0, '0, '0, 0, '0, '0);
    chk("mid_reset_count", 64'(bus.mem_fifo_count), 64'h0);
    chk("mid_reset_ovf", 64'(bus.overflow), 64'h0);
    for (int k = 0; k < 3; k++) idle();

    a_v = 0; a_d = '0; a_dat = '0;
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      if (!a_v) begin
        a_v   = 1'($urandom_range(0, 1));
        a_d   = AN'($urandom_range(0, 19));
        a_dat = $urandom;
      end
      mv   = ($urandom_range(0, 9) < 4);
      md   = AN'($urandom_range(0, 19));
      mdat = $urandom;
      step(rst, stall, a_v, a_d, a_dat, mv, md, mdat);
      if (a_v && exp_ready_last) a_v = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
